// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and line/parity levels,
// used by both the TX and RX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator: even parity is the XOR of the word,
// odd parity its complement.
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] i_data,
    input  logic          i_type,
    output logic          o_parity
);

    assign o_parity = (i_type == PARITY_ODD) ? ~^i_data : ^i_data;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter, one bit per clock: start, data LSB first, optional
// parity, stop. TX_OUT and Busy are registered from the next-state decode.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [data_width-1:0] P_data,
    input  logic                  Data_Valid,
    input  logic                  Parity_Enable,
    input  logic                  Parity_Type,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CW = (data_width > 1) ? $clog2(data_width) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(data_width - 1);

    uart_state_e           r_state;
    uart_state_e           w_state_next;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_next;
    logic [CW-1:0]         w_cnt_inc;
    logic [data_width-1:0] r_data;
    logic                  r_par;
    logic                  r_par_en;
    logic                  r_tx;
    logic                  r_busy;
    logic                  w_tx_next;
    logic                  w_busy_next;
    logic                  w_accept;
    logic                  w_parity;

    uart_tx_parity_calc #(
        .DW(data_width)
    ) u_parity (
        .i_data   (P_data),
        .i_type   (Parity_Type),
        .o_parity (w_parity)
    );

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The output registers load the value belonging to the state being
    // entered, so the accepting edge already drives the start bit.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_tx_next    = IDLE_LEVEL;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (Data_Valid) begin
                    w_accept     = 1'b1;
                    w_state_next = START;
                    w_tx_next    = START_LEVEL;
                end
            end
            START: begin
                w_state_next = DATA;
                w_cnt_next   = '0;
                w_tx_next    = r_data[0];
            end
            DATA: begin
                if (r_cnt == CNT_LAST) begin
                    if (r_par_en) begin
                        w_state_next = PARITY;
                        w_tx_next    = r_par;
                    end else begin
                        w_state_next = STOP;
                        w_tx_next    = IDLE_LEVEL;
                    end
                end else begin
                    w_cnt_next = w_cnt_inc;
                    w_tx_next  = r_data[w_cnt_inc];
                end
            end
            PARITY: begin
                w_state_next = STOP;
                w_tx_next    = IDLE_LEVEL;
            end
            STOP: begin
                if (Data_Valid) begin
                    w_accept     = 1'b1;
                    w_state_next = START;
                    w_tx_next    = START_LEVEL;
                end else begin
                    w_state_next = IDLE;
                    w_tx_next    = IDLE_LEVEL;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = IDLE_LEVEL;
            end
        endcase
    end

    assign w_busy_next = (w_state_next != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt    <= '0;
            r_data   <= '0;
            r_par    <= 1'b0;
            r_par_en <= 1'b0;
            r_tx     <= IDLE_LEVEL;
            r_busy   <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tx   <= w_tx_next;
            r_busy <= w_busy_next;
            if (w_accept) begin
                r_data   <= P_data;
                r_par_en <= Parity_Enable;
                r_par    <= w_parity;
            end
        end
    end

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: expected {TX_OUT,Busy} per cycle
// are queued when a word is offered and popped as the line is sampled.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_data;
    logic       Data_Valid;
    logic       Parity_Enable;
    logic       Parity_Type;
    logic       TX_OUT;
    logic       Busy;

    logic [1:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    uart_tx_frame #(
        .data_width(8)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .P_data        (P_data),
        .Data_Valid    (Data_Valid),
        .Parity_Enable (Parity_Enable),
        .Parity_Type   (Parity_Type),
        .TX_OUT        (TX_OUT),
        .Busy          (Busy)
    );

    always #5 CLK = ~CLK;

    // Reference frame model: {tx, busy} per cycle, start..stop.
    function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt);
        exp_q.push_back(2'b01);
        for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1});
        if (pe) exp_q.push_back({(^d) ^ pt, 1'b1});
        exp_q.push_back(2'b11);
    endfunction

    task automatic test_reset();
        RST = 1'b0; Data_Valid = 1'b1; P_data = 8'h5A;
        Parity_Enable = 1'b0; Parity_Type = 1'b0;
        repeat (3) @(negedge CLK);
        n_vec++;
        if ({TX_OUT, Busy} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_hold: {TX_OUT,Busy}=%b required 10", {TX_OUT, Busy});
        end
        Data_Valid = 1'b0;
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_vec++;
            if ({TX_OUT, Busy} !== 2'b10) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: {TX_OUT,Busy}=%b required 10", i, {TX_OUT, Busy});
            end
        end
    endtask

    task automatic test_parity_even();
        logic [10:0] seq;
        logic [1:0]  exp;
        int          k;
        seq = 11'b10101001010;
        for (int i = 0; i < 11; i++) exp_q.push_back({seq[i], 1'b1});
        P_data = 8'hA5; Parity_Enable = 1'b1; Parity_Type = 1'b0; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0; P_data = 8'h0F; Parity_Type = 1'b1; Parity_Enable = 1'b0;
        k = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_vec++;
            if ({TX_OUT, Busy} !== exp) begin
                n_err++;
                $display("FAIL even_A5 cycle %0d: {TX_OUT,Busy}=%b required %b", k, {TX_OUT, Busy}, exp);
            end
            k++;
            @(negedge CLK);
        end
        n_vec++;
        if ({TX_OUT, Busy} !== 2'b10) begin
            n_err++;
            $display("FAIL even_A5 after: {TX_OUT,Busy}=%b required 10", {TX_OUT, Busy});
        end
    endtask

    task automatic test_parity_odd();
        logic [7:0] words [2];
        logic [1:0] exp;
        int         k;
        words[0] = 8'hA5;
        words[1] = 8'h01;
        for (int w = 0; w < 2; w++) begin
            P_data = words[w]; Parity_Enable = 1'b1; Parity_Type = 1'b1; Data_Valid = 1'b1;
            push_frame(words[w], 1'b1, 1'b1);
            @(negedge CLK);
            Data_Valid = 1'b0; Parity_Type = 1'b0;
            k = 0;
            while (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                n_vec++;
                if ({TX_OUT, Busy} !== exp) begin
                    n_err++;
                    $display("FAIL odd_%h cycle %0d: {TX_OUT,Busy}=%b required %b", words[w], k, {TX_OUT, Busy}, exp);
                end
                k++;
                @(negedge CLK);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_no_parity();
        logic [1:0] exp;
        int         k;
        P_data = 8'hFF; Parity_Enable = 1'b0; Parity_Type = 1'b0; Data_Valid = 1'b1;
        push_frame(8'hFF, 1'b0, 1'b0);
        @(negedge CLK);
        Data_Valid = 1'b0; Parity_Enable = 1'b1;
        k = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_vec++;
            if ({TX_OUT, Busy} !== exp) begin
                n_err++;
                $display("FAIL nopar_FF cycle %0d: {TX_OUT,Busy}=%b required %b", k, {TX_OUT, Busy}, exp);
            end
            k++;
            @(negedge CLK);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({TX_OUT, Busy} !== 2'b10) begin
                n_err++;
                $display("FAIL nopar_idle[%0d]: {TX_OUT,Busy}=%b required 10", i, {TX_OUT, Busy});
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp;
        int         k;
        bit         sent2;
        P_data = 8'h96; Parity_Enable = 1'b1; Parity_Type = 1'b1; Data_Valid = 1'b1;
        push_frame(8'h96, 1'b1, 1'b1);
        @(negedge CLK);
        Data_Valid = 1'b0;
        k = 0;
        sent2 = 1'b0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_vec++;
            if ({TX_OUT, Busy} !== exp) begin
                n_err++;
                $display("FAIL b2b cycle %0d: {TX_OUT,Busy}=%b required %b", k, {TX_OUT, Busy}, exp);
            end
            Data_Valid = 1'b0;
            if (!sent2 && exp_q.size() == 0) begin
                P_data = 8'h3C; Parity_Enable = 1'b0; Parity_Type = 1'b0; Data_Valid = 1'b1;
                push_frame(8'h3C, 1'b0, 1'b0);
                sent2 = 1'b1;
            end
            k++;
            @(negedge CLK);
        end
        Data_Valid = 1'b0;
        n_vec++;
        if ({TX_OUT, Busy} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b after: {TX_OUT,Busy}=%b required 10", {TX_OUT, Busy});
        end
        @(negedge CLK);
    endtask

    task automatic test_ignore_mid_frame();
        logic [1:0] exp;
        int         k;
        P_data = 8'h55; Parity_Enable = 1'b1; Parity_Type = 1'b0; Data_Valid = 1'b1;
        push_frame(8'h55, 1'b1, 1'b0);
        @(negedge CLK);
        Data_Valid = 1'b0;
        k = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_vec++;
            if ({TX_OUT, Busy} !== exp) begin
                n_err++;
                $display("FAIL ignore_55 cycle %0d: {TX_OUT,Busy}=%b required %b", k, {TX_OUT, Busy}, exp);
            end
            Data_Valid = (k == 4);
            if (k == 4) begin
                P_data = 8'h00; Parity_Enable = 1'b0; Parity_Type = 1'b1;
            end
            k++;
            @(negedge CLK);
        end
        Data_Valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({TX_OUT, Busy} !== 2'b10) begin
                n_err++;
                $display("FAIL ignore_idle[%0d]: {TX_OUT,Busy}=%b required 10", i, {TX_OUT, Busy});
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [1:0] exp;
        int         k;
        P_data = 8'hC3; Parity_Enable = 1'b1; Parity_Type = 1'b0; Data_Valid = 1'b1;
        push_frame(8'hC3, 1'b1, 1'b0);
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (k = 0; k <= 5; k++) begin
            exp = exp_q.pop_front();
            n_vec++;
            if ({TX_OUT, Busy} !== exp) begin
                n_err++;
                $display("FAIL prereset_C3 cycle %0d: {TX_OUT,Busy}=%b required %b", k, {TX_OUT, Busy}, exp);
            end
            if (k < 5) @(negedge CLK);
        end
        RST = 1'b0;
        exp_q.delete();
        #1;
        n_vec++;
        if ({TX_OUT, Busy} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_abort: {TX_OUT,Busy}=%b required 10", {TX_OUT, Busy});
        end
        #1;
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            n_vec++;
            if ({TX_OUT, Busy} !== 2'b10) begin
                n_err++;
                $display("FAIL post_reset_idle[%0d]: {TX_OUT,Busy}=%b required 10", i, {TX_OUT, Busy});
            end
        end
        P_data = 8'h6E; Parity_Enable = 1'b1; Parity_Type = 1'b1; Data_Valid = 1'b1;
        push_frame(8'h6E, 1'b1, 1'b1);
        @(negedge CLK);
        Data_Valid = 1'b0;
        k = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_vec++;
            if ({TX_OUT, Busy} !== exp) begin
                n_err++;
                $display("FAIL post_reset_6E cycle %0d: {TX_OUT,Busy}=%b required %b", k, {TX_OUT, Busy}, exp);
            end
            k++;
            @(negedge CLK);
        end
        n_vec++;
        if ({TX_OUT, Busy} !== 2'b10) begin
            n_err++;
            $display("FAIL post_reset_after: {TX_OUT,Busy}=%b required 10", {TX_OUT, Busy});
        end
    endtask

    initial begin
        test_reset();
        test_parity_even();
        test_parity_odd();
        test_no_parity();
        test_back_to_back();
        test_ignore_mid_frame();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
